// File: rtl/i_cache_refill_unit_pkg.sv
// i_cache_refill_unit_pkg: shared types, constants and line-address helper for the I-cache refill unit
package i_cache_refill_unit_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_SIZE_DEF = 2;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_SIZE_DEF * 4);
  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} refill_state_t;
  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr, input int off);
    return (addr >> off) << off;
  endfunction
endpackage

// File: rtl/i_cache_refill_unit_miss_queue.sv
// i_cache_refill_unit_miss_queue: two-port miss arbitration, duplicate filtering and one-entry pending slot
module i_cache_refill_unit_miss_queue
  import i_cache_refill_unit_pkg::*;
#(
  parameter int OFF = LINE_OFFSET_BITS
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 miss_i,
  input  logic [1:0][ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                       flush_i,
  input  logic                       idle_i,
  input  logic [ADDR_WIDTH-1:0]      cur_base_i,
  output logic                       grant_o,
  output logic [ADDR_WIDTH-1:0]      grant_base_o
);
  logic pend_q, pend_d, consume, free, c0, c1;
  logic [ADDR_WIDTH-1:0] pbase_q, pbase_d, b0, b1, ab;
  always_comb begin
    b0 = line_base(miss_addr_i[0], OFF);
    b1 = line_base(miss_addr_i[1], OFF);
    consume = idle_i & pend_q;
    grant_o = idle_i & (pend_q | (|miss_i));
    grant_base_o = pend_q ? pbase_q : (miss_i[0] ? b0 : b1);
    // line that is (or is about to be) in service; misses to it are redundant
    ab = idle_i ? grant_base_o : cur_base_i;
    free = !pend_q | consume;
    c0 = miss_i[0] & (b0 != ab);
    c1 = miss_i[1] & (b1 != ab);
    pend_d = flush_i ? 1'b0 : (free & (c0 | c1)) | (pend_q & !consume);
    pbase_d = (free & (c0 | c1)) ? (c0 ? b0 : b1) : pbase_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q <= 1'b0;
      pbase_q <= '0;
    end else begin
      pend_q <= pend_d;
      pbase_q <= pbase_d;
    end
  end
endmodule

// File: rtl/i_cache_refill_unit.sv
// i_cache_refill_unit: fetches missing I-cache lines word by word from memory and delivers them whole
module i_cache_refill_unit
  import i_cache_refill_unit_pkg::*;
#(
  parameter int LINE_SIZE = LINE_SIZE_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 miss_i,
  input  logic [1:0][ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                       ext_flush_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr_o,
  input  logic                       mem_resp_valid_i,
  input  logic [31:0]                mem_resp_data_i,
  output logic [ADDR_WIDTH-1:0]      fetch_addr_o,
  output logic                       fetch_addr_valid_o,
  output logic [32*LINE_SIZE-1:0]    fetched_data_o,
  output logic                       refill_busy_o
);
  localparam int OFF = $clog2(LINE_SIZE * 4);
  localparam int CW = LINE_SIZE > 1 ? $clog2(LINE_SIZE) : 1;
  refill_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] base_q, grant_base;
  logic [32*LINE_SIZE-1:0] line_q, line_d, data_q;
  logic grant, last, outstanding;
  i_cache_refill_unit_miss_queue #(.OFF(OFF)) u_queue (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .miss_i      (miss_i),
    .miss_addr_i (miss_addr_i),
    .flush_i     (ext_flush_i),
    .idle_i      (state_q == IDLE),
    .cur_base_i  (base_q),
    .grant_o     (grant),
    .grant_base_o(grant_base)
  );
  always_comb begin
    line_d = line_q;
    line_d[cnt_q*32 +: 32] = mem_resp_data_i;
    last = int'(cnt_q) == LINE_SIZE - 1;
    // a response arriving this cycle retires the outstanding request
    outstanding = ((state_q == RESP || state_q == DRAIN) && !mem_resp_valid_i) ||
                  (state_q == REQ && mem_req_ready_i);
  end
  assign mem_req_valid_o = state_q == REQ;
  assign mem_req_addr_o = mem_req_valid_o ? base_q + (ADDR_WIDTH'(cnt_q) << 2) : '0;
  assign fetch_addr_valid_o = state_q == DONE && !ext_flush_i;
  assign fetch_addr_o = fetch_addr_valid_o ? base_q : '0;
  assign fetched_data_o = data_q;
  assign refill_busy_o = state_q != IDLE;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      line_q <= '0;
      data_q <= '0;
    end else if (ext_flush_i) begin
      state_q <= outstanding ? DRAIN : IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          state_q <= REQ;
          base_q <= grant_base;
          cnt_q <= '0;
        end
        REQ: if (mem_req_ready_i) state_q <= RESP;
        RESP: if (mem_resp_valid_i) begin
          line_q <= line_d;
          if (last) begin
            data_q <= line_d;
            cnt_q <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            state_q <= REQ;
          end
        end
        DONE: state_q <= IDLE;
        DRAIN: if (mem_resp_valid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
